// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle MIPS core: fetch, decode, execute,
// memory and write-back sequencing with a timed memory handshake.
module multicycle_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_wr,
    output logic       pc_wr,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_wr,
    output logic       mem_req,
    output logic       mem_we,
    output logic       illegal_op,
    output logic       mem_err
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_WB_R     = 4'd4;
    localparam logic [3:0] S_EXEC_I   = 4'd5;
    localparam logic [3:0] S_WB_I     = 4'd6;
    localparam logic [3:0] S_MEM_ADDR = 4'd7;
    localparam logic [3:0] S_MEM_RD   = 4'd8;
    localparam logic [3:0] S_WB_MEM   = 4'd9;
    localparam logic [3:0] S_MEM_WR   = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_JUMP     = 4'd12;
    localparam logic [3:0] S_JR       = 4'd13;
    localparam logic [3:0] S_ILLEGAL  = 4'd14;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [TO_W-1:0] WD_MAX = TO_W'(MEM_TIMEOUT);

    logic [3:0]      state;
    logic [3:0]      state_nxt;
    logic [TO_W-1:0] wd;
    logic [TO_W-1:0] wd_nxt;
    logic            in_mem;
    logic            timeout;
    logic            nxt_is_mem;
    logic            is_jr;
    logic            is_r;
    logic            is_i;
    logic            is_mem;
    logic            is_beq;
    logic            is_j;

    assign in_mem = (state == S_FETCH) || (state == S_MEM_RD) ||
                    (state == S_MEM_WR);
    // A ready arriving on the limit cycle still completes normally.
    assign timeout = in_mem && (wd == WD_MAX) && !mem_ready;

    assign is_jr  = (opcode == OP_RTYPE) && (funct == FN_JR);
    assign is_r   = (opcode == OP_RTYPE) && (funct != FN_JR);
    assign is_i   = (opcode == OP_ADDI);
    assign is_mem = (opcode == OP_LW) || (opcode == OP_SW);
    assign is_beq = (opcode == OP_BEQ);
    assign is_j   = (opcode == OP_J);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                if (mem_ready)    state_nxt = S_DECODE;
                else if (timeout) state_nxt = S_IDLE;
            end
            S_DECODE: begin
                unique case (1'b1)
                    is_jr:   state_nxt = S_JR;
                    is_r:    state_nxt = S_EXEC_R;
                    is_i:    state_nxt = S_EXEC_I;
                    is_mem:  state_nxt = S_MEM_ADDR;
                    is_beq:  state_nxt = S_BRANCH;
                    is_j:    state_nxt = S_JUMP;
                    default: state_nxt = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: state_nxt = S_WB_R;
            S_EXEC_I: state_nxt = S_WB_I;
            S_MEM_ADDR: begin
                if (opcode == OP_LW) state_nxt = S_MEM_RD;
                else                 state_nxt = S_MEM_WR;
            end
            S_MEM_RD: begin
                if (mem_ready)    state_nxt = S_WB_MEM;
                else if (timeout) state_nxt = S_IDLE;
            end
            S_MEM_WR: begin
                if (mem_ready)    state_nxt = S_FETCH;
                else if (timeout) state_nxt = S_IDLE;
            end
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH,
            S_JUMP, S_JR, S_ILLEGAL: state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign nxt_is_mem = (state_nxt == S_FETCH) || (state_nxt == S_MEM_RD) ||
                        (state_nxt == S_MEM_WR);

    always_comb begin
        wd_nxt = wd;
        if (nxt_is_mem && (state_nxt != state))
            wd_nxt = '0;
        else if (mem_req && !mem_ready && (wd != WD_MAX))
            wd_nxt = wd + TO_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            wd    <= '0;
        end else begin
            state <= state_nxt;
            wd    <= wd_nxt;
        end
    end

    always_comb begin
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        pc_src     = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_wr     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        illegal_op = 1'b0;
        mem_err    = timeout;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                ir_wr     = mem_ready;
                pc_wr     = mem_ready;
            end
            S_DECODE: alu_src_b = 2'd3;
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
            end
            S_WB_R: begin
                reg_wr  = 1'b1;
                reg_dst = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_WB_I: reg_wr = 1'b1;
            S_MEM_RD: mem_req = 1'b1;
            S_WB_MEM: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd1;
                pc_src    = 2'd1;
                pc_wr     = zero;
            end
            S_JUMP: begin
                pc_wr  = 1'b1;
                pc_src = 2'd2;
            end
            S_JR: begin
                pc_wr  = 1'b1;
                pc_src = 2'd3;
            end
            S_ILLEGAL: illegal_op = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: stimulus queues expected
// write/error events, a monitor pops and compares them.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       ir_wr, pc_wr, alu_src_a, reg_dst, mem_to_reg, reg_wr;
    logic       mem_req, mem_we, illegal_op, mem_err;
    logic [1:0] pc_src, alu_src_b, alu_op;

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(15), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .ir_wr(ir_wr), .pc_wr(pc_wr),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_wr(reg_wr), .mem_req(mem_req), .mem_we(mem_we),
        .illegal_op(illegal_op), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // {ir,pc,pc_src,src_a,src_b,alu_op,reg_dst,m2r,reg_wr,req,we,ill,err}
    logic [15:0] outs;
    assign outs = {ir_wr, pc_wr, pc_src, alu_src_a, alu_src_b, alu_op,
                   reg_dst, mem_to_reg, reg_wr, mem_req, mem_we,
                   illegal_op, mem_err};

    localparam logic [15:0] E_F   = {2'b11, 2'd0, 1'b0, 2'd1, 2'd0, 7'b0001000};
    localparam logic [15:0] E_WBR = {2'b00, 2'd0, 1'b0, 2'd0, 2'd0, 7'b1010000};
    localparam logic [15:0] E_WBI = {2'b00, 2'd0, 1'b0, 2'd0, 2'd0, 7'b0010000};
    localparam logic [15:0] E_WBM = {2'b00, 2'd0, 1'b0, 2'd0, 2'd0, 7'b0110000};
    localparam logic [15:0] E_BR  = {2'b01, 2'd1, 1'b1, 2'd0, 2'd1, 7'b0000000};
    localparam logic [15:0] E_J   = {2'b01, 2'd2, 1'b0, 2'd0, 2'd0, 7'b0000000};
    localparam logic [15:0] E_JR  = {2'b01, 2'd3, 1'b0, 2'd0, 2'd0, 7'b0000000};
    localparam logic [15:0] E_ILL = {2'b00, 2'd0, 1'b0, 2'd0, 2'd0, 7'b0000010};
    localparam logic [15:0] E_TO  = {2'b00, 2'd0, 1'b0, 2'd0, 2'd0, 7'b0001101};

    int total = 0;
    int bad = 0;
    logic [15:0] sb[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_req(input string nm, input int exp);
        int n = 0;
        while (!mem_req && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, n, exp);
    endtask

    // d waiting cycles, then one ready cycle
    task automatic serve(input int d, input logic we);
        for (int i = 0; i < d; i++) begin
            chk("req_hold", {mem_req, mem_we}, {1'b1, we});
            @(posedge clk); #1;
        end
        chk("req_last", {mem_req, mem_we}, {1'b1, we});
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
    endtask

    task automatic fetch(input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input int d);
        sb.push_back(E_F);
        opcode = op;
        funct  = fn;
        zero   = z;
        serve(d, 1'b0);
    endtask

    initial begin
        fork
            begin
                repeat (2) @(posedge clk);
                #1;
                chk("reset_outs", 32'(outs), 32'h0);
                rst_n = 1'b1;
                wait_req("boot", 1);

                fetch(6'h00, 6'h20, 1'b0, 1);
                sb.push_back(E_WBR);
                wait_req("add_lat", 3);

                fetch(6'h08, 6'h00, 1'b0, 0);
                sb.push_back(E_WBI);
                mem_ready = 1'b1;
                @(posedge clk); #1;
                mem_ready = 1'b0;
                wait_req("addi_lat", 2);

                fetch(6'h23, 6'h00, 1'b0, 0);
                sb.push_back(E_WBM);
                wait_req("lw_addr", 2);
                serve(3, 1'b0);
                wait_req("lw_wb", 1);

                fetch(6'h04, 6'h00, 1'b1, 0);
                sb.push_back(E_BR);
                wait_req("beq_taken", 2);
                fetch(6'h04, 6'h00, 1'b0, 0);
                wait_req("beq_not", 2);

                fetch(6'h02, 6'h00, 1'b0, 0);
                sb.push_back(E_J);
                wait_req("j_lat", 2);
                fetch(6'h00, 6'h08, 1'b0, 0);
                sb.push_back(E_JR);
                wait_req("jr_lat", 2);

                fetch(6'h2B, 6'h00, 1'b0, 0);
                sb.push_back(E_TO);
                wait_req("sw_addr", 2);
                for (int i = 0; i < 16; i++) begin
                    chk("sw_wait", {mem_req, mem_we}, 2'b11);
                    @(posedge clk); #1;
                end
                chk("to_idle", {mem_req, reg_wr}, 2'b00);
                wait_req("refetch", 1);

                fetch(6'h2B, 6'h00, 1'b0, 0);
                wait_req("sw2_addr", 2);
                serve(15, 1'b1);
                wait_req("sw2_done", 0);
                chk("sw2_fetch_we", mem_we, 0);

                fetch(6'h3F, 6'h00, 1'b0, 0);
                sb.push_back(E_ILL);
                wait_req("ill_lat", 2);

                fetch(6'h23, 6'h00, 1'b0, 0);
                wait_req("lw2_addr", 2);
                @(posedge clk); #1;
                chk("lw2_req", mem_req, 1);
                #2 rst_n = 1'b0;
                #1;
                chk("rst_outs", 32'(outs), 32'h0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                wait_req("rst_boot", 1);

                fetch(6'h00, 6'h22, 1'b0, 0);
                sb.push_back(E_WBR);
                wait_req("sub_lat", 3);
                repeat (2) @(posedge clk);
                #1;
                chk("sb_empty", sb.size(), 0);
            end
            forever begin
                @(negedge clk);
                if (rst_n && (ir_wr | pc_wr | reg_wr | illegal_op | mem_err)) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_event got=%h want=none", outs);
                    end else begin
                        logic [15:0] want;
                        want = sb.pop_front();
                        if (outs !== want) begin
                            bad++;
                            $display("FAIL event got=%h want=%h", outs, want);
                        end
                    end
                end
            end
        join_any
        disable fork;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
